hash_table_ctrl: RTL

Sequencing controller for the MAC hash table. It accepts lookup requests (destination-MAC forwarding) and insert requests (source-MAC learning) and arbitrates between them. For each request it computes the bucket index by XOR-folding the key, then drives a single-port, direct-mapped table RAM through read/compare/write cycles. It also owns table initialisation after reset and on-demand flushing.

---
 rtl/hash_pkg.sv | 64 ++++++
 rtl/hash_table_ram.sv | 37 +++
 rtl/hash_table_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/hash_pkg.sv
// -----------------------------------------------------------------------------
// hash_pkg
// Shared types and helpers for the MAC hash table controller.
//   - default widths (key, value, bucket index)
//   - hash_entry_t : table word layout {valid, key, value} at default widths
//   - ins_status_e : insert outcome reported with ins_done_o
//   - ht_state_e   : controller FSM states
//   - grant_e      : last-grant flag for lookup/insert round-robin
//   - fold_index() : XOR-fold of a key into a bucket index
// -----------------------------------------------------------------------------
package hash_pkg;

    localparam int KEY_W_DEF = 48;
    localparam int VAL_W_DEF = 8;
    localparam int IDX_W_DEF = 10;

    // Upper bounds for the fold helper; callers zero-extend into these.
    localparam int MAX_KEY_W = 64;
    localparam int MAX_IDX_W = 16;

    typedef struct packed {
        logic                 valid;
        logic [KEY_W_DEF-1:0] key;
        logic [VAL_W_DEF-1:0] value;
    } hash_entry_t;

    typedef enum logic [1:0] {
        INS_NEW     = 2'd0,
        INS_UPDATE  = 2'd1,
        INS_REPLACE = 2'd2
    } ins_status_e;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_RD   = 3'd2,
        ST_CMP  = 3'd3,
        ST_WR   = 3'd4
    } ht_state_e;

    typedef enum logic {
        GNT_LKUP = 1'b0,
        GNT_INS  = 1'b1
    } grant_e;

    // Key bit i lands on index bit (i mod idx_w): equivalent to XOR-ing the
    // idx_w-bit chunks of the key taken from the LSB, with the last partial
    // chunk zero-extended. Bits above idx_w in the result stay zero.
    function automatic logic [MAX_IDX_W-1:0] fold_index(
        input logic [MAX_KEY_W-1:0] key,
        input int                   key_w,
        input int                   idx_w
    );
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_KEY_W; i++) begin
            if (i < key_w) begin
                idx[i % idx_w] = idx[i % idx_w] ^ key[i];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hash_table_ram.sv
// -----------------------------------------------------------------------------
// hash_table_ram
// Single-port synchronous table RAM, 2**ADDR_W words of DATA_W bits.
// One access per cycle; read data is registered (valid the cycle after a
// read). The array has no reset; the controller initialises it by sweeping.
//   clk_i   : clock
//   en_i    : access enable
//   we_i    : write when enabled, otherwise read
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data (holds between reads)
// -----------------------------------------------------------------------------
module hash_table_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 57
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem[addr_i] <= wdata_i;
            end else begin
                rdata_o <= mem[addr_i];
            end
        end
    end

endmodule

// File: rtl/hash_table_ctrl.sv
// -----------------------------------------------------------------------------
// hash_table_ctrl
// Sequencing controller for the MAC hash table. Arbitrates lookup and insert
// requests (round-robin), folds the key into a bucket index and runs the
// direct-mapped table RAM through read / compare / write cycles. Also sweeps
// the table invalid after reset and on a flush request.
//   clk_i, rst_i                    : clock, async active-high reset
//   lkup_valid_i/ready_o/key_i      : lookup request handshake
//   rslt_valid_o/hit_o/value_o      : one-cycle lookup result
//   ins_valid_i/ready_o/key_i/value_i : insert request handshake
//   ins_done_o, ins_status_o        : one-cycle insert completion + outcome
//   clear_i                         : flush request pulse
//   busy_o                          : high whenever the FSM is not idle
//
// state | meaning
// ------+----------------------------------------------------------
// INIT  | write valid=0 to one address per cycle, 0 .. 2**IDX_W-1
// IDLE  | serve pending clear, else grant one request and latch it
// RD    | read the bucket at the latched index
// CMP   | compare entry; lookup -> result, insert -> status
// WR    | write {1, key, value} for an insert, report done
// -----------------------------------------------------------------------------
module hash_table_ctrl
    import hash_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int VAL_W = VAL_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lkup_valid_i,
    output logic             lkup_ready_o,
    input  logic [KEY_W-1:0] lkup_key_i,
    output logic             rslt_valid_o,
    output logic             rslt_hit_o,
    output logic [VAL_W-1:0] rslt_value_o,
    input  logic             ins_valid_i,
    output logic             ins_ready_o,
    input  logic [KEY_W-1:0] ins_key_i,
    input  logic [VAL_W-1:0] ins_value_i,
    output logic             ins_done_o,
    output logic [1:0]       ins_status_o,
    input  logic             clear_i,
    output logic             busy_o
);

    localparam int ENTRY_W = 1 + KEY_W + VAL_W;

    ht_state_e         state_q, state_d;
    logic [IDX_W-1:0]  sweep_q;
    grant_e            last_grant_q;
    logic              clear_pend_q;
    logic              op_ins_q;
    logic [KEY_W-1:0]  key_q;
    logic [VAL_W-1:0]  value_q;
    logic [IDX_W-1:0]  idx_q;
    ins_status_e       status_q;

    logic              is_idle;
    logic              lkup_go;
    logic              ins_go;
    logic [KEY_W-1:0]  sel_key;
    logic [IDX_W-1:0]  sel_idx;

    logic              ram_en;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_addr;
    logic [ENTRY_W-1:0] ram_wdata;
    logic [ENTRY_W-1:0] ram_rdata;

    logic              ent_valid;
    logic [KEY_W-1:0]  ent_key;
    logic [VAL_W-1:0]  ent_value;
    logic              key_match;

    // ---------------------------------------------------------------------
    // Arbitration: on a tie the port that did not win last time is granted;
    // a lone requester always wins. At most one go can be high.
    // ---------------------------------------------------------------------
    assign is_idle      = (state_q == ST_IDLE);
    assign busy_o       = !is_idle;
    assign lkup_ready_o = is_idle && !clear_pend_q &&
                          (!ins_valid_i || last_grant_q == GNT_INS);
    assign ins_ready_o  = is_idle && !clear_pend_q &&
                          (!lkup_valid_i || last_grant_q == GNT_LKUP);
    assign lkup_go      = lkup_valid_i && lkup_ready_o;
    assign ins_go       = ins_valid_i && ins_ready_o;

    // One fold instance serves both ports since only one is granted.
    assign sel_key = ins_go ? ins_key_i : lkup_key_i;
    assign sel_idx = IDX_W'(fold_index(MAX_KEY_W'(sel_key), KEY_W, IDX_W));

    // Table word layout: {valid, key, value}
    assign ent_valid = ram_rdata[ENTRY_W-1];
    assign ent_key   = ram_rdata[VAL_W +: KEY_W];
    assign ent_value = ram_rdata[VAL_W-1:0];
    assign key_match = ent_valid && (ent_key == key_q);

    hash_table_ram #(
        .ADDR_W (IDX_W),
        .DATA_W (ENTRY_W)
    ) u_ram (
        .clk_i   (clk_i),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = idx_q;
        ram_wdata = '0;
        case (state_q)
            ST_INIT: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = sweep_q;
                // A clear on the last sweep cycle restarts instead of exiting.
                if (!clear_i && sweep_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear_pend_q) begin
                    state_d = ST_INIT;
                end else if (lkup_go || ins_go) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                ram_en  = 1'b1;
                state_d = ST_CMP;
            end
            ST_CMP: begin
                state_d = op_ins_q ? ST_WR : ST_IDLE;
            end
            ST_WR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_wdata = {1'b1, key_q, value_q};
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Sweep counter, clear tracking, request latch and registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sweep_q      <= '0;
            last_grant_q <= GNT_INS;
            clear_pend_q <= 1'b0;
            op_ins_q     <= 1'b0;
            key_q        <= '0;
            value_q      <= '0;
            idx_q        <= '0;
            status_q     <= INS_NEW;
            rslt_valid_o <= 1'b0;
            rslt_hit_o   <= 1'b0;
            rslt_value_o <= '0;
            ins_done_o   <= 1'b0;
            ins_status_o <= 2'd0;
        end else begin
            rslt_valid_o <= 1'b0;
            ins_done_o   <= 1'b0;

            // Held at zero outside INIT so every sweep starts at address 0.
            if (state_q == ST_INIT) begin
                sweep_q <= clear_i ? '0 : sweep_q + IDX_W'(1);
            end else begin
                sweep_q <= '0;
            end

            // A clear seen during INIT just restarts the sweep above.
            if (is_idle && clear_pend_q) begin
                clear_pend_q <= 1'b0;
            end else if (clear_i && state_q != ST_INIT) begin
                clear_pend_q <= 1'b1;
            end

            if (lkup_go || ins_go) begin
                op_ins_q     <= ins_go;
                key_q        <= sel_key;
                value_q      <= ins_value_i;
                idx_q        <= sel_idx;
                last_grant_q <= ins_go ? GNT_INS : GNT_LKUP;
            end

            if (state_q == ST_CMP) begin
                if (op_ins_q) begin
                    if (!ent_valid) begin
                        status_q <= INS_NEW;
                    end else if (key_match) begin
                        status_q <= INS_UPDATE;
                    end else begin
                        status_q <= INS_REPLACE;
                    end
                end else begin
                    rslt_valid_o <= 1'b1;
                    rslt_hit_o   <= key_match;
                    rslt_value_o <= key_match ? ent_value : '0;
                end
            end

            if (state_q == ST_WR) begin
                ins_done_o   <= 1'b1;
                ins_status_o <= status_q;
            end
        end
    end

endmodule
